// File: rtl/clock_alarm_multi.sv
// BCD 24h time-of-day counter with an ALARM_NUM-entry alarm table, ring/snooze FSM and beeper.
// Optional CLOCK_ALARM_H12_EN: 12-hour display on disp_hh/disp_pm; internal time stays 24h.

module clock_alarm_entry (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic        on_in,
    input  logic [15:0] hhmm_in,
    input  logic [15:0] cur_hhmm,
    output logic        hit
);
    logic        on_q;
    logic [15:0] hhmm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_q   <= 1'b0;
            hhmm_q <= '0;
        end else if (we) begin
            on_q   <= on_in;
            hhmm_q <= hhmm_in;
        end
    end

    assign hit = on_q && (hhmm_q == cur_hhmm);
endmodule

module clock_alarm_multi #(
    parameter int CLK_HZ     = 50000000,
    parameter int ALARM_NUM  = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    parameter int IDXW       = (ALARM_NUM > 1) ? $clog2(ALARM_NUM) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_inc_h,
    input  logic            set_inc_m,
    input  logic            set_zero_s,
    input  logic            alm_we,
    input  logic [IDXW-1:0] alm_idx,
    input  logic            alm_on,
    input  logic [15:0]     alm_hhmm,
    input  logic            ack,
    input  logic            snooze,
    output logic [23:0]     time_bcd,
    output logic [7:0]      disp_hh,
    output logic            disp_pm,
    output logic            sec_pulse,
    output logic            ring,
    output logic [IDXW-1:0] ring_idx,
    output logic            beep,
    output logic            alm_err
);
    localparam int PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int TONE_DIV = (CLK_HZ / 2000 > 1) ? CLK_HZ / 2000 : 1;
    localparam int TDW      = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam int TW       = 12;

    typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;
    typedef struct packed {
        logic        on;
        logic [15:0] hhmm;
    } alm_wr_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic [PW-1:0]  presc;
    logic [7:0]     hh, mm, ss;
    logic           wrap, any_set, adv_q;

    assign wrap     = (presc == PW'(CLK_HZ - 1));
    assign any_set  = set_inc_h | set_inc_m | set_zero_s;
    assign time_bcd = {hh, mm, ss};

    // A set pulse coinciding with a wrap swallows that second's advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            hh        <= 8'h00;
            mm        <= 8'h00;
            ss        <= 8'h00;
            sec_pulse <= 1'b0;
            adv_q     <= 1'b0;
        end else begin
            presc     <= (wrap || set_zero_s) ? '0 : presc + 1'b1;
            sec_pulse <= wrap;
            adv_q     <= wrap && !any_set;
            if (any_set) begin
                if (set_inc_h)  hh <= bcd_inc(hh, 8'h23);
                if (set_inc_m)  mm <= bcd_inc(mm, 8'h59);
                if (set_zero_s) ss <= 8'h00;
            end else if (wrap) begin
                ss <= bcd_inc(ss, 8'h59);
                if (ss == 8'h59) begin
                    mm <= bcd_inc(mm, 8'h59);
                    if (mm == 8'h59) hh <= bcd_inc(hh, 8'h23);
                end
            end
        end
    end

    alm_wr_t             wr;
    logic                idx_ok, bcd_ok, wr_ok, kill, match;
    logic [ALARM_NUM-1:0] hit;
    logic [IDXW-1:0]     match_idx;

    assign wr     = {alm_on, alm_hhmm};
    assign idx_ok = (32'(alm_idx) < ALARM_NUM);
    assign bcd_ok = (wr.hhmm[15:8] <= 8'h23) && (wr.hhmm[11:8] <= 4'd9) &&
                    (wr.hhmm[7:4] <= 4'd5) && (wr.hhmm[3:0] <= 4'd9);
    assign wr_ok  = alm_we && idx_ok && bcd_ok;

    for (genvar i = 0; i < ALARM_NUM; i++) begin : g_ent
        clock_alarm_entry u_ent (
            .clk      (clk),
            .rst_n    (rst_n),
            .we       (wr_ok && (32'(alm_idx) == i)),
            .on_in    (wr.on),
            .hhmm_in  (wr.hhmm),
            .cur_hhmm ({hh, mm}),
            .hit      (hit[i])
        );
    end

    always_comb begin
        match_idx = '0;
        for (int i = ALARM_NUM - 1; i >= 0; i--)
            if (hit[i]) match_idx = IDXW'(i);
    end

    // adv_q marks a tick-caused transition, so set actions can never fire an alarm.
    assign match = adv_q && (ss == 8'h00) && (|hit);
    assign kill  = wr_ok && !wr.on && (alm_idx == ring_idx);

    state_t         state;
    logic [TW-1:0]  timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ring     <= 1'b0;
            ring_idx <= '0;
            timer    <= '0;
            alm_err  <= 1'b0;
        end else begin
            alm_err <= alm_we && !(idx_ok && bcd_ok);
            case (state)
                S_IDLE: begin
                    if (match) begin
                        state    <= S_RING;
                        ring     <= 1'b1;
                        ring_idx <= match_idx;
                        timer    <= TW'(RING_SEC);
                    end
                end
                S_RING: begin
                    if (kill || ack) begin
                        state <= S_IDLE;
                        ring  <= 1'b0;
                    end else if (snooze) begin
                        state <= S_SNOOZE;
                        ring  <= 1'b0;
                        timer <= TW'(SNOOZE_MIN * 60);
                    end else if (sec_pulse) begin
                        if (timer <= TW'(1)) begin
                            state <= S_IDLE;
                            ring  <= 1'b0;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (kill || ack) begin
                        state <= S_IDLE;
                    end else if (sec_pulse) begin
                        if (timer <= TW'(1)) begin
                            state <= S_RING;
                            ring  <= 1'b1;
                            timer <= TW'(RING_SEC);
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ring  <= 1'b0;
                end
            endcase
        end
    end

    logic [TDW-1:0] tone_cnt;
    logic           tone;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt <= '0;
            tone     <= 1'b0;
        end else if (tone_cnt == TDW'(TONE_DIV - 1)) begin
            tone_cnt <= '0;
            tone     <= ~tone;
        end else begin
            tone_cnt <= tone_cnt + 1'b1;
        end
    end

    assign beep = ring & tone;

`ifdef CLOCK_ALARM_H12_EN
    logic [4:0] h_bin, h12;
    always_comb begin
        h_bin = 5'(hh[7:4]) * 5'd10 + 5'(hh[3:0]);
        if (h_bin == 5'd0)       h12 = 5'd12;
        else if (h_bin > 5'd12)  h12 = h_bin - 5'd12;
        else                     h12 = h_bin;
        disp_hh = (h12 >= 5'd10) ? {4'd1, 4'(h12 - 5'd10)} : {4'd0, h12[3:0]};
        disp_pm = (h_bin >= 5'd12);
    end
`else
    assign disp_hh = hh;
    assign disp_pm = 1'b0;
`endif

endmodule

// File: tb/tb_clock_alarm_multi.sv
// Directed bench for clock_alarm_multi: vector tables for alarm writes and display,
// hand-written sequences for rollover, ring timeout, snooze, ack and disable.

module tb_clock_alarm_multi;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        set_inc_h, set_inc_m, set_zero_s;
    logic        alm_we, alm_on, ack, snooze;
    logic [2:0]  alm_idx;
    logic [15:0] alm_hhmm;
    logic [23:0] time_bcd;
    logic [7:0]  disp_hh;
    logic        disp_pm, sec_pulse, ring, beep, alm_err;
    logic [2:0]  ring_idx;

    int   checks = 0;
    int   errors = 0;
    int   n;
    logic flag, ring_seen, b0, b1;

    typedef struct {
        logic [2:0]  idx;
        logic        on;
        logic [15:0] hhmm;
        logic        err;
    } wr_vec_t;

    typedef struct {
        int         n_inc;
        logic [7:0] hh;
        logic [7:0] disp;
        logic       pm;
    } disp_vec_t;

    wr_vec_t   wv[9];
    disp_vec_t dv[5];

    clock_alarm_multi #(
        .CLK_HZ(10), .ALARM_NUM(5), .SNOOZE_MIN(1), .RING_SEC(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .set_inc_h(set_inc_h), .set_inc_m(set_inc_m), .set_zero_s(set_zero_s),
        .alm_we(alm_we), .alm_idx(alm_idx), .alm_on(alm_on), .alm_hhmm(alm_hhmm),
        .ack(ack), .snooze(snooze),
        .time_bcd(time_bcd), .disp_hh(disp_hh), .disp_pm(disp_pm),
        .sec_pulse(sec_pulse), .ring(ring), .ring_idx(ring_idx),
        .beep(beep), .alm_err(alm_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_set(input logic h, input logic m, input logic s);
        set_inc_h = h; set_inc_m = m; set_zero_s = s;
        @(negedge clk);
        set_inc_h = 1'b0; set_inc_m = 1'b0; set_zero_s = 1'b0;
    endtask

    task automatic inc_h(input int cnt);
        repeat (cnt) pulse_set(1'b1, 1'b0, 1'b0);
    endtask

    task automatic inc_m(input int cnt);
        repeat (cnt) pulse_set(1'b0, 1'b1, 1'b0);
    endtask

    task automatic wait_sec();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
            ring_seen |= ring;
        end while (!sec_pulse && k < 40);
        if (!sec_pulse) begin
            checks++; errors++;
            $display("FAIL sec_timeout: got no sec_pulse in %0d cycles, required one", k);
        end
    endtask

    task automatic wait_ring(input int bound, input string name);
        int k = 0;
        while (!ring && k < bound) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!ring) begin
            errors++;
            $display("FAIL %s: got ring=0 after %0d cycles, required ring=1", name, k);
        end
    endtask

    task automatic write_alm(input logic [2:0] idx, input logic on, input logic [15:0] hhmm);
        alm_we = 1'b1; alm_idx = idx; alm_on = on; alm_hhmm = hhmm;
        @(negedge clk);
        alm_we = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        wv[0] = '{3'd2, 1'b1, 16'h0730, 1'b0};
        wv[1] = '{3'd1, 1'b1, 16'h0600, 1'b0};
        wv[2] = '{3'd3, 1'b1, 16'h0600, 1'b0};
        wv[3] = '{3'd0, 1'b1, 16'h2400, 1'b1};
        wv[4] = '{3'd5, 1'b1, 16'h0600, 1'b1};
        wv[5] = '{3'd0, 1'b1, 16'h0560, 1'b1};
        wv[6] = '{3'd0, 1'b1, 16'h0A00, 1'b1};
        wv[7] = '{3'd4, 1'b0, 16'h2359, 1'b0};
        wv[8] = '{3'd7, 1'b1, 16'h0000, 1'b1};
`ifdef CLOCK_ALARM_H12_EN
        dv[0] = '{0,  8'h13, 8'h01, 1'b1};
        dv[1] = '{11, 8'h00, 8'h12, 1'b0};
        dv[2] = '{12, 8'h12, 8'h12, 1'b1};
        dv[3] = '{11, 8'h23, 8'h11, 1'b1};
        dv[4] = '{2,  8'h01, 8'h01, 1'b0};
`else
        dv[0] = '{0,  8'h13, 8'h13, 1'b0};
        dv[1] = '{11, 8'h00, 8'h00, 1'b0};
        dv[2] = '{12, 8'h12, 8'h12, 1'b0};
        dv[3] = '{11, 8'h23, 8'h23, 1'b0};
        dv[4] = '{2,  8'h01, 8'h01, 1'b0};
`endif
        rst_n = 1'b0;
        set_inc_h = 1'b0; set_inc_m = 1'b0; set_zero_s = 1'b0;
        alm_we = 1'b0; alm_idx = '0; alm_on = 1'b0; alm_hhmm = '0;
        ack = 1'b0; snooze = 1'b0;
        ring_seen = 1'b0;

        #12;
        check("rst_time", 32'(time_bcd), 32'h0);
        check("rst_outs", {27'd0, sec_pulse, ring, beep, alm_err, disp_pm}, 32'h0);
        check("rst_idx", 32'(ring_idx), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sec_pulse && n < 40);
        check("first_tick", n, 10);

        // Simultaneous h+m pulses: hours wrap 23->00 without carry.
        repeat (24) pulse_set(1'b1, 1'b1, 1'b0);
        check("h_wrap", 32'(time_bcd[23:8]), 32'h0024);
        inc_m(35);
        check("m_59", 32'(time_bcd[23:8]), 32'h0059);
        inc_m(1);
        check("m_wrap", 32'(time_bcd[23:8]), 32'h0000);
        inc_h(23);
        inc_m(59);
        pulse_set(1'b0, 1'b0, 1'b1);
        check("set_2359", 32'(time_bcd), 32'h235900);

        flag = 1'b0;
        for (int k = 0; k < 59; k++) begin
            wait_sec();
            if (time_bcd[23:8] != 16'h2359) flag = 1'b1;
        end
        check("carry_hold", 32'(flag), 32'h0);
        check("pre_roll", 32'(time_bcd), 32'h235959);
        wait_sec();
        check("day_roll", 32'(time_bcd), 32'h000000);

        for (int i = 0; i < 9; i++) begin
            write_alm(wv[i].idx, wv[i].on, wv[i].hhmm);
            check($sformatf("wr_err%0d", i), 32'(alm_err), 32'(wv[i].err));
            @(negedge clk);
            check($sformatf("wr_err_end%0d", i), 32'(alm_err), 32'h0);
        end

        // Alarm 2 at 07:30: ring one cycle after time shows 07:30:00.
        inc_h(7);
        inc_m(29);
        pulse_set(1'b0, 1'b0, 1'b1);
        repeat (59) wait_sec();
        check("t072959", 32'(time_bcd), 32'h072959);
        wait_sec();
        check("t073000", 32'(time_bcd), 32'h073000);
        check("ring_lag", 32'(ring), 32'h0);
        @(negedge clk);
        check("ring_rise", 32'(ring), 32'h1);
        check("ring_idx2", 32'(ring_idx), 32'h2);
        b0 = beep;
        @(negedge clk);
        b1 = beep;
        check("beep_tone", 32'(b0 ^ b1), 32'h1);

        wait_sec();
        check("ring_s1", 32'(ring), 32'h1);
        wait_sec();
        wait_sec();
        check("ring_s3", 32'(ring), 32'h1);
        @(negedge clk);
        check("ring_timeout", 32'(ring), 32'h0);
        b0 = beep;
        @(negedge clk);
        b1 = beep;
        check("beep_off", 32'(b0 | b1), 32'h0);

        // Snooze for one minute, a second snooze mid-way must be ignored.
        write_alm(3'd2, 1'b1, 16'h0731);
        wait_ring(700, "ring_0731");
        check("t073100", 32'(time_bcd), 32'h073100);
        snooze = 1'b1;
        @(negedge clk);
        snooze = 1'b0;
        check("snooze_drop", 32'(ring), 32'h0);
        ring_seen = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            wait_sec();
            if (k == 10) begin
                snooze = 1'b1;
                @(negedge clk);
                snooze = 1'b0;
                ring_seen |= ring;
            end
        end
        check("snooze_quiet", 32'(ring_seen), 32'h0);
        @(negedge clk);
        check("snooze_rering", 32'(ring), 32'h1);
        check("snooze_idx", 32'(ring_idx), 32'h2);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("ack_stop", 32'(ring), 32'h0);

        // Entries 1 and 3 both at 06:00: lowest index wins.
        inc_h(22);
        inc_m(27);
        check("set_0559", 32'(time_bcd[23:8]), 32'h0559);
        pulse_set(1'b0, 1'b0, 1'b1);
        repeat (59) wait_sec();
        check("t055959", 32'(time_bcd), 32'h055959);
        wait_sec();
        check("t060000", 32'(time_bcd), 32'h060000);
        @(negedge clk);
        check("ring_0600", 32'(ring), 32'h1);
        check("low_idx_wins", 32'(ring_idx), 32'h1);
        ack = 1'b1; snooze = 1'b1;
        @(negedge clk);
        ack = 1'b0; snooze = 1'b0;
        check("ack_snz", 32'(ring), 32'h0);

        // After ack+snooze the FSM must be idle and accept the 06:01 match on entry 3.
        write_alm(3'd3, 1'b1, 16'h0601);
        wait_ring(700, "ring_0601");
        check("idle_rearm", 32'(ring_idx), 32'h3);
        write_alm(3'd3, 1'b1, 16'h0601);
        check("on_wr_keep", 32'(ring), 32'h1);
        write_alm(3'd3, 1'b0, 16'h0601);
        check("off_wr_kill", 32'(ring), 32'h0);

        inc_h(7);
        inc_m(4);
        check("set_1305", 32'(time_bcd[23:8]), 32'h1305);
        for (int i = 0; i < 5; i++) begin
            inc_h(dv[i].n_inc);
            check($sformatf("disp_hh24_%0d", i), 32'(time_bcd[23:16]), 32'(dv[i].hh));
            check($sformatf("disp_hh_%0d", i), 32'(disp_hh), 32'(dv[i].disp));
            check($sformatf("disp_pm_%0d", i), 32'(disp_pm), 32'(dv[i].pm));
        end

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_time", 32'(time_bcd), 32'h0);
        check("async_rst_idx", 32'(ring_idx), 32'h0);
        check("async_rst_outs", {28'd0, sec_pulse, ring, beep, alm_err}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
